// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcode/funct encodings, ALU operations and the ID/EX
// control word used by the pipelined control unit.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ADDIU = 6'b001001,
    OP_SLTI  = 6'b001010,
    OP_SLTIU = 6'b001011,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_XORI  = 6'b001110,
    OP_LUI   = 6'b001111,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_LL    = 6'b110000,
    OP_SC    = 6'b111000,
    OP_HALT  = 6'b111111
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    MEM_MEM = 2'b00,
    MEM_PC4 = 2'b01,
    MEM_ALU = 2'b10
  } memtoreg_t;

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_UPPER = 2'b10
  } extsel_t;

  typedef enum logic [1:0] {
    RD_RD  = 2'b00,
    RD_RT  = 2'b01,
    RD_R31 = 2'b10
  } regdst_t;

  // ALU B-operand source select
  localparam logic [1:0] ALUSRC_REG   = 2'b00;
  localparam logic [1:0] ALUSRC_IMM   = 2'b01;
  localparam logic [1:0] ALUSRC_SHAMT = 2'b10;

  typedef struct packed {
    logic      jump;
    logic      branch;
    logic      bne;
    logic      dren;
    logic      dwen;
    logic      halt;
    logic      regw;
    logic      lui;
    logic      jr;
    logic      ll;
    logic      sc;
    memtoreg_t memtoreg;
    logic [1:0] alusrc;
    aluop_t    aluop;
    extsel_t   extsel;
    regdst_t   regdst;
  } control_word_t;

  localparam control_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ll_sc_monitor.sv
// LL/SC reservation tracker for one core.
// Ports: clk/rst_n (async active-low), ll_commit/ll_addr set the link,
// sc_commit clears it, snoop_inv/snoop_addr invalidate a matching link,
// sc_success reports (combinationally) whether sc_addr hits a live link.
// Addresses are compared at word granularity.
module ll_sc_monitor
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ll_commit,
  input  logic [WORD_W-1:0] ll_addr,
  input  logic              sc_commit,
  input  logic [WORD_W-1:0] sc_addr,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              sc_success
);

  logic                link_valid_r;
  logic [WORD_W-1:2]   link_addr_r;
  logic                link_valid_s;
  logic [WORD_W-1:2]   link_addr_s;
  logic                snoop_hit_s;
  logic                clear_s;
  logic                unused_byte_bits;

  assign unused_byte_bits = ^{ll_addr[1:0], sc_addr[1:0], snoop_addr[1:0]};

  // Uses the current (pre-clear) link, so an SC committing this cycle
  // still sees its own reservation.
  assign sc_success  = link_valid_r && (sc_addr[WORD_W-1:2] == link_addr_r);
  assign snoop_hit_s = snoop_inv && (snoop_addr[WORD_W-1:2] == link_addr_r);
  assign clear_s     = sc_commit || snoop_hit_s;

  // Next link state: clears are applied before the LL set, so LL wins.
  always_comb begin
    link_valid_s = link_valid_r;
    link_addr_s  = link_addr_r;
    if (ll_commit) begin
      link_valid_s = 1'b1;
      link_addr_s  = ll_addr[WORD_W-1:2];
    end else if (clear_s) begin
      link_valid_s = 1'b0;
      link_addr_s  = link_addr_r;
    end else begin
      link_valid_s = link_valid_r;
      link_addr_s  = link_addr_r;
    end
  end

  // Link register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid_r <= 1'b0;
      link_addr_r  <= '0;
    end else begin
      link_valid_r <= link_valid_s;
      link_addr_r  <= link_addr_s;
    end
  end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: decodes the IF/ID instruction and registers the
// control word into the ID/EX latch with flush/stall/halt handling.
// Ports: CLK/nRST (async active-low); instr/instr_valid from IF/ID;
// stall/flush from hazard logic; ll_*/sc_*/snoop_* feed the reservation
// monitor; ctrl/ctrl_valid/illegal are the registered ID/EX outputs;
// halted is the halt indication; sc_success is the SC outcome;
// ctrl_cpuid reports the core index.
module control_unit_pipe
  import cpu_types_pkg::*;
#(
  parameter int CPUID       = 0,
  parameter int WORD_W      = 32,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              ll_commit,
  input  logic [WORD_W-1:0] ll_addr,
  input  logic              sc_commit,
  input  logic [WORD_W-1:0] sc_addr,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output control_word_t     ctrl,
  output logic              ctrl_valid,
  output logic              illegal,
  output logic              halted,
  output logic              sc_success,
  output logic [7:0]        ctrl_cpuid
);

  typedef struct packed {
    control_word_t cw;
    logic          illegal;
  } decode_t;

  // Unrecognised encodings return a bubble with the illegal flag set.
  function automatic decode_t decode(input logic [5:0] op, input logic [5:0] fn);
    decode_t d;
    d.cw      = CTRL_BUBBLE;
    d.illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        d.cw.regw     = 1'b1;
        d.cw.regdst   = RD_RD;
        d.cw.memtoreg = MEM_ALU;
        d.cw.alusrc   = ALUSRC_REG;
        case (fn)
          FN_SLL:  begin d.cw.aluop = ALU_SLL; d.cw.alusrc = ALUSRC_SHAMT; end
          FN_SRL:  begin d.cw.aluop = ALU_SRL; d.cw.alusrc = ALUSRC_SHAMT; end
          FN_ADD,
          FN_ADDU: d.cw.aluop = ALU_ADD;
          FN_SUB,
          FN_SUBU: d.cw.aluop = ALU_SUB;
          FN_AND:  d.cw.aluop = ALU_AND;
          FN_OR:   d.cw.aluop = ALU_OR;
          FN_XOR:  d.cw.aluop = ALU_XOR;
          FN_NOR:  d.cw.aluop = ALU_NOR;
          FN_SLT:  d.cw.aluop = ALU_SLT;
          FN_SLTU: d.cw.aluop = ALU_SLTU;
          FN_JR: begin
            d.cw.jr       = 1'b1;
            d.cw.regw     = 1'b0;
            d.cw.memtoreg = MEM_MEM;
          end
          default: d.illegal = 1'b1;
        endcase
      end
      OP_J: d.cw.jump = 1'b1;
      OP_JAL: begin
        d.cw.jump     = 1'b1;
        d.cw.regw     = 1'b1;
        d.cw.regdst   = RD_R31;
        d.cw.memtoreg = MEM_PC4;
      end
      OP_BEQ, OP_BNE: begin
        d.cw.branch = 1'b1;
        d.cw.bne    = (op == OP_BNE);
        d.cw.aluop  = ALU_SUB;
        d.cw.extsel = EXT_SIGN;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        d.cw.regw     = 1'b1;
        d.cw.regdst   = RD_RT;
        d.cw.memtoreg = MEM_ALU;
        d.cw.alusrc   = ALUSRC_IMM;
        case (op)
          OP_ADDI, OP_ADDIU: begin d.cw.aluop = ALU_ADD;  d.cw.extsel = EXT_SIGN; end
          OP_SLTI:           begin d.cw.aluop = ALU_SLT;  d.cw.extsel = EXT_SIGN; end
          OP_SLTIU:          begin d.cw.aluop = ALU_SLTU; d.cw.extsel = EXT_SIGN; end
          OP_ANDI:           begin d.cw.aluop = ALU_AND;  d.cw.extsel = EXT_ZERO; end
          OP_ORI:            begin d.cw.aluop = ALU_OR;   d.cw.extsel = EXT_ZERO; end
          OP_XORI:           begin d.cw.aluop = ALU_XOR;  d.cw.extsel = EXT_ZERO; end
          OP_LUI: begin
            d.cw.lui    = 1'b1;
            d.cw.aluop  = ALU_ADD;
            d.cw.extsel = EXT_UPPER;
          end
          default: d.illegal = 1'b1;
        endcase
      end
      OP_LW, OP_LL: begin
        d.cw.dren     = 1'b1;
        d.cw.regw     = 1'b1;
        d.cw.ll       = (op == OP_LL);
        d.cw.regdst   = RD_RT;
        d.cw.memtoreg = MEM_MEM;
        d.cw.alusrc   = ALUSRC_IMM;
        d.cw.aluop    = ALU_ADD;
        d.cw.extsel   = EXT_SIGN;
      end
      OP_SW: begin
        d.cw.dwen   = 1'b1;
        d.cw.alusrc = ALUSRC_IMM;
        d.cw.aluop  = ALU_ADD;
        d.cw.extsel = EXT_SIGN;
      end
      // SC writes its success flag into rt; the datapath gates dwen with it.
      OP_SC: begin
        d.cw.dwen   = 1'b1;
        d.cw.regw   = 1'b1;
        d.cw.sc     = 1'b1;
        d.cw.regdst = RD_RT;
        d.cw.alusrc = ALUSRC_IMM;
        d.cw.aluop  = ALU_ADD;
        d.cw.extsel = EXT_SIGN;
      end
      OP_HALT: d.cw.halt = 1'b1;
      default: d.illegal = 1'b1;
    endcase
    d.cw = d.illegal ? CTRL_BUBBLE : d.cw;
    return d;
  endfunction

  decode_t       dec_s;
  control_word_t ctrl_r;
  logic          ctrl_valid_r;
  logic          illegal_r;
  logic          halt_seen_r;
  logic          unused_instr;

  assign unused_instr = ^instr[25:6];

  // Combinational decode of the IF/ID word
  always_comb begin
    dec_s = decode(instr[31:26], instr[5:0]);
  end

  // ID/EX register: flush > stall > sticky-halt bubble > normal issue
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctrl_r       <= CTRL_BUBBLE;
      ctrl_valid_r <= 1'b0;
      illegal_r    <= 1'b0;
      halt_seen_r  <= 1'b0;
    end else if (flush) begin
      ctrl_r       <= CTRL_BUBBLE;
      ctrl_valid_r <= 1'b0;
      illegal_r    <= 1'b0;
    end else if (stall) begin
      ctrl_r       <= ctrl_r;
      ctrl_valid_r <= ctrl_valid_r;
      illegal_r    <= illegal_r;
    end else if (HALT_STICKY && halt_seen_r) begin
      ctrl_r       <= CTRL_BUBBLE;
      ctrl_valid_r <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      ctrl_r       <= instr_valid ? dec_s.cw : CTRL_BUBBLE;
      ctrl_valid_r <= instr_valid && !dec_s.illegal;
      illegal_r    <= instr_valid && dec_s.illegal;
      if (instr_valid && dec_s.cw.halt) begin
        halt_seen_r <= 1'b1;
      end
    end
  end

  assign ctrl       = ctrl_r;
  assign ctrl_valid = ctrl_valid_r;
  assign illegal    = illegal_r;
  assign halted     = HALT_STICKY ? halt_seen_r : (ctrl_r.halt & ctrl_valid_r);
  assign ctrl_cpuid = CPUID[7:0];

  ll_sc_monitor #(
    .WORD_W(WORD_W)
  ) u_ll_sc_monitor (
    .clk       (CLK),
    .rst_n     (nRST),
    .ll_commit (ll_commit),
    .ll_addr   (ll_addr),
    .sc_commit (sc_commit),
    .sc_addr   (sc_addr),
    .snoop_inv (snoop_inv),
    .snoop_addr(snoop_addr),
    .sc_success(sc_success)
  );

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench for control_unit_pipe: stimulus pushes the expected
// ID/EX state for each clock, a monitor pops and compares after the edge.
module tb_control_unit_pipe;
  import cpu_types_pkg::*;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [31:0]   instr;
  logic          instr_valid, stall, flush;
  logic          ll_commit, sc_commit, snoop_inv;
  logic [31:0]   ll_addr, sc_addr, snoop_addr;
  control_word_t ctrl;
  logic          ctrl_valid, illegal, halted, sc_success;
  logic [7:0]    ctrl_cpuid;

  control_unit_pipe #(.CPUID(0), .WORD_W(32), .HALT_STICKY(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .ll_commit(ll_commit), .ll_addr(ll_addr),
    .sc_commit(sc_commit), .sc_addr(sc_addr), .snoop_inv(snoop_inv),
    .snoop_addr(snoop_addr), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
    .illegal(illegal), .halted(halted), .sc_success(sc_success),
    .ctrl_cpuid(ctrl_cpuid)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    control_word_t cw;
    logic          v;
    logic          ill;
    logic          h;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;
  int    errors = 0;
  int    checks = 0;

  // flags order: jump,branch,bne,dren,dwen,halt,regw,lui,jr,ll,sc
  function automatic control_word_t cw(input logic [10:0] f, input memtoreg_t m,
                                       input logic [1:0] s, input aluop_t a,
                                       input extsel_t x, input regdst_t r);
    control_word_t c;
    {c.jump, c.branch, c.bne, c.dren, c.dwen, c.halt, c.regw, c.lui, c.jr, c.ll, c.sc} = f;
    c.memtoreg = m;
    c.alusrc   = s;
    c.aluop    = a;
    c.extsel   = x;
    c.regdst   = r;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Drive one issue slot at the negedge and queue the expected post-edge state
  task automatic step(input logic [31:0] i, input logic v, input logic st, input logic fl,
                      input control_word_t e, input logic ev, input logic eill,
                      input logic eh, input string nm);
    exp_t x;
    instr = i; instr_valid = v; stall = st; flush = fl;
    x.cw = e; x.v = ev; x.ill = eill; x.h = eh;
    exp_q.push_back(x);
    name_q.push_back(nm);
    @(negedge CLK);
  endtask

  // Monitor: compare the registered outputs shortly after each active edge
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if ({ctrl, ctrl_valid, illegal, halted} !== mon_e) begin
        errors++;
        $display("FAIL %s: got ctrl=%h v=%b ill=%b h=%b expected ctrl=%h v=%b ill=%b h=%b",
                 mon_n, ctrl, ctrl_valid, illegal, halted, mon_e.cw, mon_e.v, mon_e.ill, mon_e.h);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    control_word_t c_addu, c_lw, c_sw, c_beq, c_slti, c_jal, c_sc, c_halt;
    c_addu = cw(11'b00000010000, MEM_ALU, 2'b00, ALU_ADD, EXT_ZERO, RD_RD);
    c_lw   = cw(11'b00010010000, MEM_MEM, 2'b01, ALU_ADD, EXT_SIGN, RD_RT);
    c_sw   = cw(11'b00001000000, MEM_MEM, 2'b01, ALU_ADD, EXT_SIGN, RD_RD);
    c_beq  = cw(11'b01000000000, MEM_MEM, 2'b00, ALU_SUB, EXT_SIGN, RD_RD);
    c_slti = cw(11'b00000010000, MEM_ALU, 2'b01, ALU_SLT, EXT_SIGN, RD_RT);
    c_jal  = cw(11'b10000010000, MEM_PC4, 2'b00, ALU_SLL, EXT_ZERO, RD_R31);
    c_sc   = cw(11'b00001010001, MEM_MEM, 2'b01, ALU_ADD, EXT_SIGN, RD_RT);
    c_halt = cw(11'b00000100000, MEM_MEM, 2'b00, ALU_SLL, EXT_ZERO, RD_RD);

    instr = 32'h0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    ll_commit = 1'b0; sc_commit = 1'b0; snoop_inv = 1'b0;
    ll_addr = 32'h0; sc_addr = 32'h0; snoop_addr = 32'h0;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_flags", {29'h0, ctrl_valid, illegal, halted}, 32'h0);
    chk("rst_cpuid", {24'h0, ctrl_cpuid}, 32'h0);
    chk("rst_link_invalid", {31'h0, sc_success}, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    step(32'h00221821, 1'b1, 1'b0, 1'b0, c_addu, 1'b1, 1'b0, 1'b0, "addu");
    step(32'h8C220004, 1'b1, 1'b0, 1'b0, c_lw,   1'b1, 1'b0, 1'b0, "lw");
    for (int k = 0; k < 3; k++)
      step(32'hAC220008, 1'b1, 1'b1, 1'b0, c_lw, 1'b1, 1'b0, 1'b0, "stall_hold_lw");
    step(32'hAC220008, 1'b1, 1'b0, 1'b0, c_sw, 1'b1, 1'b0, 1'b0, "sw_after_stall");
    step(32'h10220003, 1'b1, 1'b0, 1'b1, CTRL_BUBBLE, 1'b0, 1'b0, 1'b0, "flush_beq");
    step(32'h10220003, 1'b1, 1'b1, 1'b1, CTRL_BUBBLE, 1'b0, 1'b0, 1'b0, "flush_over_stall");
    step(32'h10220003, 1'b1, 1'b0, 1'b0, c_beq,  1'b1, 1'b0, 1'b0, "beq");
    step(32'h28220005, 1'b1, 1'b0, 1'b0, c_slti, 1'b1, 1'b0, 1'b0, "slti");
    step(32'h0C000010, 1'b1, 1'b0, 1'b0, c_jal,  1'b1, 1'b0, 1'b0, "jal");
    step(32'hE0220000, 1'b1, 1'b0, 1'b0, c_sc,   1'b1, 1'b0, 1'b0, "sc");
    step(32'h00221821, 1'b0, 1'b0, 1'b0, CTRL_BUBBLE, 1'b0, 1'b0, 1'b0, "invalid_slot");
    step(32'hF800003F, 1'b1, 1'b0, 1'b0, CTRL_BUBBLE, 1'b0, 1'b1, 1'b0, "illegal_opcode");
    step(32'h0000003F, 1'b1, 1'b0, 1'b0, CTRL_BUBBLE, 1'b0, 1'b1, 1'b0, "illegal_funct");
    step(32'h00221821, 1'b1, 1'b0, 1'b0, c_addu, 1'b1, 1'b0, 1'b0, "addu_clears_illegal");
    step(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, c_halt, 1'b1, 1'b0, 1'b1, "halt");
    step(32'h00221821, 1'b1, 1'b0, 1'b0, CTRL_BUBBLE, 1'b0, 1'b0, 1'b1, "halted_bubble1");
    step(32'h00221821, 1'b1, 1'b0, 1'b0, CTRL_BUBBLE, 1'b0, 1'b0, 1'b1, "halted_bubble2");

    // Asynchronous reset in the middle of a cycle
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_halted", {31'h0, halted}, 32'h0);
    chk("async_rst_valid", {31'h0, ctrl_valid}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    step(32'h00221821, 1'b1, 1'b0, 1'b0, c_addu, 1'b1, 1'b0, 1'b0, "addu_after_reset");
    instr_valid = 1'b0;

    // LL/SC reservation
    ll_commit = 1'b1; ll_addr = 32'h100;
    @(negedge CLK);
    ll_commit = 1'b0; sc_addr = 32'h100;
    #1 chk("sc_after_ll", {31'h0, sc_success}, 32'h1);
    sc_addr = 32'h104;
    #1 chk("sc_other_word", {31'h0, sc_success}, 32'h0);
    sc_addr = 32'h100; sc_commit = 1'b1;
    #1 chk("sc_commit_preclear", {31'h0, sc_success}, 32'h1);
    @(negedge CLK);
    sc_commit = 1'b0;
    #1 chk("sc_repeat", {31'h0, sc_success}, 32'h0);

    ll_commit = 1'b1; ll_addr = 32'h200;
    @(negedge CLK);
    ll_commit = 1'b0; snoop_inv = 1'b1; snoop_addr = 32'h202; sc_addr = 32'h200;
    #1 chk("sc_before_snoop", {31'h0, sc_success}, 32'h1);
    @(negedge CLK);
    snoop_inv = 1'b0;
    #1 chk("sc_after_snoop", {31'h0, sc_success}, 32'h0);

    ll_commit = 1'b1; ll_addr = 32'h400;
    @(negedge CLK);
    ll_commit = 1'b0; snoop_inv = 1'b1; snoop_addr = 32'h500;
    @(negedge CLK);
    snoop_inv = 1'b0; sc_addr = 32'h400;
    #1 chk("snoop_miss_keeps_link", {31'h0, sc_success}, 32'h1);

    ll_commit = 1'b1; ll_addr = 32'h300; snoop_inv = 1'b1; snoop_addr = 32'h300;
    @(negedge CLK);
    ll_commit = 1'b0; snoop_inv = 1'b0; sc_addr = 32'h300;
    #1 chk("ll_wins_over_snoop", {31'h0, sc_success}, 32'h1);

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
